prog_counter: RTL and testbench

Parametrised programmable counter, successor to the plain up/down counter used by the shift-add datapath. It adds a programmable terminal value (`limit`), a programmable step, and three terminal modes: wrap, saturate and one-shot. A start/busy/done handshake lets the multiplier control FSM launch a count and wait for completion.

---
 rtl/counter_pkg.sv | 30 +++
 rtl/prog_counter_next.sv | 80 ++++++++
 rtl/prog_counter.sv | 119 +++++++++++
 tb/tb_prog_counter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/counter_pkg.sv
// Shared types for the programmable counter: FSM states, terminal modes and
// the decode of the raw 2-bit mode input.
package counter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        WRAP    = 2'd0,
        SAT     = 2'd1,
        ONESHOT = 2'd2
    } mode_t;

    localparam logic [1:0] MODE_WRAP = 2'b00;
    localparam logic [1:0] MODE_SAT  = 2'b01;

    // The reserved encoding 11 folds into ONESHOT so the mode register never
    // holds an undefined value.
    function automatic mode_t decode_mode(input logic [1:0] m);
        case (m)
            MODE_WRAP: decode_mode = WRAP;
            MODE_SAT:  decode_mode = SAT;
            default:   decode_mode = ONESHOT;
        endcase
    endfunction

endpackage

// File: rtl/prog_counter_next.sv
// Combinational next-count logic: one step in the configured direction with
// wrap / saturate / one-shot handling of the bound, computed in N+1 bits.
module prog_counter_next
    import counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic [N-1:0]      count_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic [N-1:0]      limit_i,
    input  logic              up_i,
    input  logic [1:0]        mode_i,
    output logic [N-1:0]      next_o,
    output logic              wrap_o,
    output logic              term_o
);

    localparam logic [N:0] ONE = {{N{1'b0}}, 1'b1};

    mode_t      mode;
    logic [N:0] cnt_x;
    logic [N:0] stp_x;
    logic [N:0] lim_x;
    logic [N:0] bound;
    logic [N:0] sum;
    logic [N:0] alt;
    logic [N:0] res;

    assign mode  = mode_t'(mode_i);
    assign cnt_x = {1'b0, count_i};
    assign stp_x = {{(N + 1 - STEP_W){1'b0}}, step_i};
    assign lim_x = {1'b0, limit_i};
    assign bound = up_i ? lim_x : '0;

    always_comb begin
        sum    = cnt_x + stp_x;
        alt    = '0;
        res    = cnt_x;
        wrap_o = 1'b0;
        if (up_i) begin
            if (sum > lim_x) begin
                if (mode == WRAP) begin
                    alt    = sum - lim_x - ONE;
                    res    = (alt > lim_x) ? '0 : alt;
                    wrap_o = 1'b1;
                end else begin
                    res = lim_x;
                end
            end else begin
                res = sum;
            end
        end else begin
            if (cnt_x < stp_x) begin
                if (mode == WRAP) begin
                    // Modular N+1-bit result; anything past the bound clamps to it.
                    alt    = cnt_x + lim_x + ONE - stp_x;
                    res    = (alt > lim_x) ? lim_x : alt;
                    wrap_o = 1'b1;
                end else begin
                    res = '0;
                end
            end else begin
                res = cnt_x - stp_x;
            end
        end
    end

    // SAT only flags the first arrival at the bound; ONESHOT flags any arrival.
    always_comb begin
        case (mode)
            SAT:     term_o = (res == bound) && (cnt_x != bound);
            ONESHOT: term_o = (res == bound);
            default: term_o = 1'b0;
        endcase
    end

    assign next_o = res[N-1:0];

endmodule

// File: rtl/prog_counter.sv
// Programmable counter with limit, step and wrap/saturate/one-shot modes,
// controlled through a start/abort command pair and a busy/done handshake.
module prog_counter
    import counter_pkg::*;
#(
    parameter int N      = 8,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              en,
    input  logic              up_down,
    input  logic [1:0]        mode,
    input  logic [STEP_W-1:0] step,
    input  logic [N-1:0]      limit,
    input  logic [N-1:0]      data_in,
    output logic [N-1:0]      data_out,
    output logic              busy,
    output logic              done,
    output logic              wrap,
    output logic              end_count,
    output logic              at_limit,
    output logic [1:0]        state_o
);

    state_t            state_q, state_d;
    logic [N-1:0]      count_q, count_d;
    logic [N-1:0]      limit_q;
    logic [STEP_W-1:0] step_q;
    logic              up_q;
    mode_t             mode_q;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              wrap_q, wrap_d;

    logic [N-1:0]      nxt;
    logic              nxt_wrap;
    logic              nxt_term;
    logic              run_step;

    prog_counter_next #(.N(N), .STEP_W(STEP_W)) u_next (
        .count_i (count_q),
        .step_i  (step_q),
        .limit_i (limit_q),
        .up_i    (up_q),
        .mode_i  (mode_q),
        .next_o  (nxt),
        .wrap_o  (nxt_wrap),
        .term_o  (nxt_term)
    );

    // A counting edge happens only when no command overrides it.
    assign run_step = (state_q == RUN) && en && !abort && !start;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = IDLE;
        end else if (start) begin
            state_d = RUN;
        end else begin
            case (state_q)
                RUN:     if (run_step && nxt_term && mode_q == ONESHOT) state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        count_d = count_q;
        if (abort)         count_d = count_q;
        else if (start)    count_d = (data_in > limit) ? limit : data_in;
        else if (run_step) count_d = nxt;
        busy_d = (state_d == RUN);
        done_d = run_step && nxt_term;
        wrap_d = run_step && nxt_wrap;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            wrap_q  <= 1'b0;
            limit_q <= '0;
            step_q  <= '0;
            up_q    <= 1'b0;
            mode_q  <= WRAP;
        end else begin
            count_q <= count_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            wrap_q  <= wrap_d;
            if (start && !abort) begin
                limit_q <= limit;
                step_q  <= step;
                up_q    <= up_down;
                mode_q  <= decode_mode(mode);
            end
        end
    end

    assign data_out  = count_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign wrap      = wrap_q;
    assign end_count = (count_q == '0);
    assign at_limit  = (count_q == limit_q);
    assign state_o   = state_q;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: directed scenarios plus random commands,
// checked cycle by cycle against an arithmetic reference model.
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0, abort = 1'b0, en = 1'b0, up_down = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [3:0] step = 4'd0;
    logic [7:0] limit = 8'd0, data_in = 8'd0;
    logic [7:0] data_out;
    logic       busy, done, wrap, end_count, at_limit;
    logic [1:0] state_o;

    int n_checks = 0;
    int n_fail   = 0;

    // Expected word: {data_out[7:0], busy, done, wrap, end_count, at_limit}
    logic [12:0] exp_q[$];

    // Reference model state
    int m_cnt = 0, m_lim = 0, m_step = 0, m_mode = 0, m_state = 0;
    bit m_up = 1'b0;

    prog_counter #(.N(8), .STEP_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .en        (en),
        .up_down   (up_down),
        .mode      (mode),
        .step      (step),
        .limit     (limit),
        .data_in   (data_in),
        .data_out  (data_out),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap),
        .end_count (end_count),
        .at_limit  (at_limit),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    // Monitor: every cycle the DUT presents a sampled output, pop and compare.
    always @(negedge clk) begin
        logic [12:0] e, g;
        if (!rst && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = {data_out, busy, done, wrap, end_count, at_limit};
            n_checks++;
            if (g !== e) begin
                n_fail++;
                $display("FAIL scoreboard @%0t: got data=%0d busy=%b done=%b wrap=%b end=%b lim=%b expected data=%0d busy=%b done=%b wrap=%b end=%b lim=%b",
                         $time, g[12:5], g[4], g[3], g[2], g[1], g[0],
                         e[12:5], e[4], e[3], e[2], e[1], e[0]);
            end
        end
    end

    // Reference model: applies the counter rules to the inputs of one edge.
    task automatic model_step(output logic [12:0] e);
        int n, tv, prev;
        bit over;
        bit d = 1'b0, w = 1'b0;
        if (abort) begin
            m_state = 0;
        end else if (start) begin
            m_cnt   = (int'(data_in) > int'(limit)) ? int'(limit) : int'(data_in);
            m_lim   = limit;
            m_step  = step;
            m_up    = up_down;
            m_mode  = (mode == 2'd0) ? 0 : (mode == 2'd1) ? 1 : 2;
            m_state = 1;
        end else if (m_state == 1 && en) begin
            prev = m_cnt;
            tv   = m_up ? m_lim : 0;
            n    = m_up ? m_cnt + m_step : m_cnt - m_step;
            over = m_up ? (n > m_lim) : (n < 0);
            if (m_mode == 0) begin
                if (over) begin
                    w = 1'b1;
                    if (m_up) begin
                        n = n - (m_lim + 1);
                        if (n > m_lim) n = 0;
                    end else begin
                        n = (m_cnt + m_lim + 1 - m_step) & 511;
                        if (n > m_lim) n = m_lim;
                    end
                end
            end else begin
                if (over) n = tv;
                if (m_mode == 1) begin
                    d = (n == tv) && (prev != tv);
                end else if (n == tv) begin
                    d = 1'b1;
                    m_state = 2;
                end
            end
            m_cnt = n;
        end else if (m_state == 2) begin
            m_state = 0;
        end
        e = {8'(m_cnt), m_state == 1, d, w, m_cnt == 0, m_cnt == m_lim};
    endtask

    // Driver: inputs are set just after a rising edge; expectation is queued
    // once the edge has happened so the monitor checks it at the next falling edge.
    task automatic cyc();
        logic [12:0] e;
        model_step(e);
        @(posedge clk);
        exp_q.push_back(e);
        #1;
    endtask

    task automatic run(input int n, input logic en_v);
        en = en_v;
        repeat (n) cyc();
    endtask

    task automatic do_start(input logic ud, input logic [1:0] md, input logic [3:0] st,
                            input logic [7:0] lim, input logic [7:0] din);
        up_down = ud; mode = md; step = st; limit = lim; data_in = din;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("reset data_out", data_out, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset wrap", wrap, 0);
        check("reset end_count", end_count, 1);
        check("reset at_limit", at_limit, 1);

        // WRAP up: 5, 8, 1, 4, 7, 0, 3
        do_start(1'b1, 2'b00, 4'd3, 8'd9, 8'd5);
        run(6, 1'b1);
        // SAT down: 6, 2, 0 then hold
        do_start(1'b0, 2'b01, 4'd4, 8'd200, 8'd6);
        run(6, 1'b1);
        // ONESHOT up: 0, 4, 8, 10 then DONE, IDLE
        do_start(1'b1, 2'b10, 4'd4, 8'd10, 8'd0);
        run(6, 1'b1);
        // Pause, abort, start+abort, restart during RUN
        do_start(1'b1, 2'b00, 4'd1, 8'd100, 8'd10);
        run(3, 1'b0);
        run(2, 1'b1);
        abort = 1'b1; cyc(); abort = 1'b0;
        run(2, 1'b1);
        data_in = 8'd50; start = 1'b1; abort = 1'b1; cyc();
        start = 1'b0; abort = 1'b0;
        run(2, 1'b1);
        do_start(1'b1, 2'b00, 4'd2, 8'd100, 8'd20);
        run(2, 1'b1);
        do_start(1'b1, 2'b00, 4'd2, 8'd100, 8'd3);
        run(2, 1'b1);
        // Boundaries: clamp on load, mode 11, step 0, live limit change
        do_start(1'b1, 2'b00, 4'd1, 8'd100, 8'd250);
        run(3, 1'b1);
        do_start(1'b0, 2'b11, 4'd5, 8'd50, 8'd12);
        run(5, 1'b1);
        do_start(1'b1, 2'b00, 4'd0, 8'd20, 8'd7);
        run(4, 1'b1);
        do_start(1'b1, 2'b10, 4'd0, 8'd20, 8'd20);
        run(3, 1'b1);
        do_start(1'b1, 2'b01, 4'd2, 8'd30, 8'd20);
        limit = 8'd5;
        run(8, 1'b1);

        // Asynchronous reset in the middle of a RUN at count 37
        do_start(1'b1, 2'b00, 4'd1, 8'd100, 8'd37);
        run(2, 1'b0);
        @(negedge clk);
        #2;
        check("drain before reset", exp_q.size(), 0);
        check("pre-reset count", data_out, 37);
        rst = 1'b1;
        #1;
        check("async reset data_out", data_out, 0);
        check("async reset busy", busy, 0);
        check("async reset end_count", end_count, 1);
        check("async reset at_limit", at_limit, 1);
        #1 rst = 1'b0;
        m_cnt = 0; m_lim = 0; m_step = 0; m_mode = 0; m_state = 0; m_up = 1'b0;
        @(posedge clk);
        #1;

        // Random command and configuration traffic
        for (int i = 0; i < 1500; i++) begin
            start   = ($urandom_range(0, 19) == 0);
            abort   = ($urandom_range(0, 49) == 0);
            en      = ($urandom_range(0, 3) != 0);
            up_down = $urandom_range(0, 1);
            mode    = 2'($urandom_range(0, 3));
            step    = 4'($urandom_range(0, 15));
            limit   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                  : 8'($urandom_range(0, 20));
            data_in = 8'($urandom_range(0, 255));
            cyc();
        end
        start = 1'b0; abort = 1'b0; en = 1'b0;

        for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
        #1;
        check("scoreboard drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
